// File: rtl/edge_window_3x3.sv
// RGB-to-luma conversion and registered 3x3 luma window with two internal line buffers.
// Define EDGE_LUMA_EN for weighted luma; otherwise the G channel is used as luma.
module edge_window_3x3 #(
    parameter  int LINE_WIDTH = 640,
    localparam int COL_W      = $clog2(LINE_WIDTH + 1)
) (
    input  logic        I_CORE_CLK,
    input  logic        I_RST,
    input  logic [23:0] I_PIX_DATA,
    input  logic        I_VSYNC,
    input  logic        I_HSYNC,
    input  logic        I_DE,
    output logic [71:0] O_WIN,
    output logic        O_WIN_VALID,
    output logic        O_VSYNC,
    output logic        O_HSYNC,
    output logic        O_DE,
    output logic        O_LOCKED,
    output logic        O_LINE_OVF
);

    localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

    typedef enum logic {WAIT_VS, ACTIVE} state_t;

    state_t state_q;
    logic   locked_q;

    logic [7:0]       y_d;
    logic             vs_rise, de_fall;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       row_q, row_d;

    logic [7:0]       y1_q, y1_d;
    logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [COL_W-1:0] col1_q, col1_d;
    logic [1:0]       row1_q, row1_d;

    logic [71:0] win_q, win_d;
    logic        valid_q, valid_d;
    logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic        ovf_q, ovf_d;

    logic [7:0]    lb0_q [LINE_WIDTH];
    logic [7:0]    lb1_q [LINE_WIDTH];
    logic [AW-1:0] lb_addr;
    logic [7:0]    lb0_rd, lb1_rd;
    logic          in_range;

`ifdef EDGE_LUMA_EN
    logic [15:0] prod_r, prod_g, prod_b, luma_sum;
    assign prod_r   = 16'(I_PIX_DATA[23:16]) * 16'd77;
    assign prod_g   = 16'(I_PIX_DATA[15:8])  * 16'd150;
    assign prod_b   = 16'(I_PIX_DATA[7:0])   * 16'd29;
    assign luma_sum = prod_r + prod_g + prod_b;
    assign y_d      = 8'(luma_sum >> 8);
`else
    logic unused_rb;
    assign unused_rb = ^{I_PIX_DATA[23:16], I_PIX_DATA[7:0]};
    assign y_d       = I_PIX_DATA[15:8];
`endif

    // Edges are taken against the stage-1 copies of the raw inputs.
    assign vs_rise  = I_VSYNC & ~vs1_q;
    assign de_fall  = ~I_DE & de1_q;
    assign in_range = col1_q < COL_W'(LINE_WIDTH);
    assign lb_addr  = col1_q[AW-1:0];
    assign lb0_rd   = lb0_q[lb_addr];
    assign lb1_rd   = lb1_q[lb_addr];

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (vs_rise || de_fall) begin
            col_d = '0;
        end else if (I_DE && col_q != COL_W'(LINE_WIDTH)) begin
            col_d = col_q + COL_W'(1);
        end
        if (vs_rise) begin
            row_d = '0;
        end else if (de_fall && row_q != 2'd2) begin
            row_d = row_q + 2'd1;
        end

        y1_d   = y_d;
        de1_d  = I_DE;
        hs1_d  = I_HSYNC;
        vs1_d  = I_VSYNC;
        col1_d = col_q;
        row1_d = row_q;

        win_d = win_q;
        if (de1_q && in_range) begin
            for (int r = 0; r < 3; r++) begin
                win_d[8*(3*r)   +: 8] = win_q[8*(3*r+1) +: 8];
                win_d[8*(3*r+1) +: 8] = win_q[8*(3*r+2) +: 8];
            end
            win_d[8*2 +: 8] = lb1_rd;
            win_d[8*5 +: 8] = lb0_rd;
            win_d[8*8 +: 8] = y1_q;
        end
        valid_d = de1_q && locked_q && (row1_q >= 2'd2) && (col1_q >= COL_W'(2)) && in_range;
        de2_d   = de1_q;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        ovf_d   = vs_rise ? 1'b0 : (ovf_q | (de1_q & ~in_range));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
        if (I_RST) begin
            col_q   <= '0;
            row_q   <= '0;
            y1_q    <= '0;
            de1_q   <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            col1_q  <= '0;
            row1_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            de2_q   <= 1'b0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            y1_q    <= y1_d;
            de1_q   <= de1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            col1_q  <= col1_d;
            row1_q  <= row1_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            de2_q   <= de2_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge I_CORE_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q  <= WAIT_VS;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_VS: if (vs_rise) begin
                    state_q  <= ACTIVE;
                    locked_q <= 1'b1;
                end
                ACTIVE:  locked_q <= 1'b1;
                default: state_q  <= WAIT_VS;
            endcase
        end
    end

    // NOTE: line buffers have no reset; row gating keeps stale contents out of valid windows.
    always_ff @(posedge I_CORE_CLK) begin
        if (de1_q && in_range) begin
            lb0_q[lb_addr] <= y1_q;
            lb1_q[lb_addr] <= lb0_rd;
        end
    end

    assign O_WIN       = win_q;
    assign O_WIN_VALID = valid_q;
    assign O_DE        = de2_q;
    assign O_HSYNC     = hs2_q;
    assign O_VSYNC     = vs2_q;
    assign O_LOCKED    = locked_q;
    assign O_LINE_OVF  = ovf_q;

endmodule
